dmem_arbiter: RTL

- Shares the single data-memory port between two requesters: the CPU load/store path and the VGA framebuffer fetcher.
- Sits between franken_riscv/vga and dmem; dmem becomes single-ported with 1-cycle synchronous read latency.
- Uses a req/gnt handshake with a registered command stage, and tags returned read data back to its owner.
- Includes a starvation guard so video fetch cannot lock out the CPU indefinitely.

---
 rtl/dmem_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-ported data memory: the CPU load/store path and the VGA fetcher.
// Registered command stage, a delayed owner tag for read returns, and a starvation guard against video lock-out.
module dmem_arbiter #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int MAX_VGA_RUN = 4
) (
  input  logic              CLOCK_50,
  input  logic              resetn,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    PRIO_VGA = 1'b0,
    PRIO_CPU = 1'b1
  } prio_e;

  localparam int            RUN_W   = 4;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VGA_RUN);

  prio_e             prio_q, prio_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              cpu_win, vga_win;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Owner tag travels beside the command: rd = a read is in flight, own = 1 for VGA.
  logic              rd_a_q, rd_a_d;
  logic              own_a_q, own_a_d;
  logic              rd_b_q, rd_b_d;
  logic              own_b_q, own_b_d;

  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              vga_rvalid_q, vga_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;

  // Grant decision: VGA wins ties unless it has used up its contested run.
  always_comb begin
    cpu_win = cpu_req & (~vga_req | (prio_q == PRIO_CPU));
    vga_win = vga_req & ~cpu_win;
  end

  assign cpu_gnt = cpu_win;
  assign vga_gnt = vga_win;

  always_comb begin
    run_d  = run_q;
    prio_d = prio_q;
    if (!cpu_req || cpu_win) begin
      run_d  = '0;
      prio_d = PRIO_VGA;
    end else if (vga_win) begin
      // cpu_req is high here, so this VGA grant was contested.
      if ((run_q + 4'd1) >= RUN_MAX) begin
        run_d  = RUN_MAX;
        prio_d = PRIO_CPU;
      end else begin
        run_d  = run_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      prio_q <= PRIO_VGA;
      run_q  <= '0;
    end else begin
      prio_q <= prio_d;
      run_q  <= run_d;
    end
  end

  // Stage A: register the granted command and its owner tag.
  always_comb begin
    mem_en_d    = cpu_win | vga_win;
    mem_we_d    = cpu_win & cpu_we;
    mem_be_d    = cpu_win ? cpu_be : 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (cpu_win) begin
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
    end else if (vga_win) begin
      mem_addr_d  = vga_addr;
    end
    rd_a_d  = vga_win | (cpu_win & ~cpu_we);
    own_a_d = vga_win;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_a_q      <= 1'b0;
      own_a_q     <= 1'b0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_a_q      <= rd_a_d;
      own_a_q     <= own_a_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Stage B: tag lines up with mem_rdata; steer the word to its owner.
  always_comb begin
    rd_b_d       = rd_a_q;
    own_b_d      = own_a_q;
    cpu_rvalid_d = rd_b_q & ~own_b_q;
    vga_rvalid_d = rd_b_q & own_b_q;
    cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
    vga_rdata_d  = vga_rvalid_d ? mem_rdata : vga_rdata_q;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rd_b_q       <= 1'b0;
      own_b_q      <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vga_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      vga_rdata_q  <= '0;
    end else begin
      rd_b_q       <= rd_b_d;
      own_b_q      <= own_b_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vga_rvalid_q <= vga_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vga_rdata_q  <= vga_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign vga_rvalid = vga_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign vga_rdata  = vga_rdata_q;

endmodule
